xor_bank_acc: RTL and testbench

Parametrised, clocked successor to the quad XOR gate: a WIDTH-bit bank of 2-input XOR/XNOR gates with registered outputs, a registered reduction-parity output, and a frame accumulation mode. In accumulation mode the block folds a stream of beats into a running XOR checksum and reports it at end of frame. It sits in the component library next to the 74xx models and serves as a parity/checksum building block for bus and serial models.

---
 rtl/xor_bank_acc.sv | 137 +++++++++++++
 tb/tb_xor_bank_acc.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/xor_bank_acc.sv
// WIDTH-bit XOR/XNOR gate bank with registered outputs, reduction parity and
// a frame accumulation mode that folds beats into a running XOR checksum.
module xor_bank_acc #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_last,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   y,
  output logic               par,
  output logic               out_valid,
  output logic [COUNT_W-1:0] beats,
  output logic               abort
);

  localparam logic [1:0] MODE_XOR  = 2'b00;
  localparam logic [1:0] MODE_XNOR = 2'b01;
  localparam logic [1:0] MODE_ACC  = 2'b10;
  localparam logic [1:0] MODE_NOP  = 2'b11;
  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  state_t             fsm, fsm_d;
  logic [WIDTH-1:0]   acc, acc_d;
  logic [COUNT_W-1:0] cnt, cnt_d;
  logic [WIDTH-1:0]   y_d;
  logic               par_d;
  logic               out_valid_d;
  logic [COUNT_W-1:0] beats_d;
  logic               abort_d;

  logic [WIDTH-1:0]   x_c;
  logic [WIDTH-1:0]   fold_c;
  logic [COUNT_W-1:0] cnt_inc_c;

  assign x_c       = a ^ b;
  assign fold_c    = acc ^ x_c;
  assign cnt_inc_c = (cnt == CNT_MAX) ? cnt : COUNT_W'(cnt + 1'b1);

  // State and output registers; reset drops any open frame without abort
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      y         <= '0;
      par       <= 1'b0;
      out_valid <= 1'b0;
      beats     <= '0;
      abort     <= 1'b0;
    end else begin
      fsm       <= fsm_d;
      acc       <= acc_d;
      cnt       <= cnt_d;
      y         <= y_d;
      par       <= par_d;
      out_valid <= out_valid_d;
      beats     <= beats_d;
      abort     <= abort_d;
    end
  end

  // Next-state: accumulator, beat counter and frame state
  always_comb begin
    fsm_d = fsm;
    acc_d = acc;
    cnt_d = cnt;
    if (in_valid) begin
      case (mode)
        MODE_XOR, MODE_XNOR: begin
          fsm_d = IDLE;
          acc_d = '0;
          cnt_d = '0;
        end
        MODE_ACC: begin
          if (in_last) begin
            fsm_d = IDLE;
            acc_d = '0;
            cnt_d = '0;
          end else begin
            fsm_d = ACC;
            acc_d = fold_c;
            cnt_d = cnt_inc_c;
          end
        end
        MODE_NOP: begin
          fsm_d = fsm;
        end
        default: begin
          fsm_d = fsm;
        end
      endcase
    end
  end

  // Output next values; pulses default low, data outputs hold
  always_comb begin
    y_d         = y;
    beats_d     = beats;
    out_valid_d = 1'b0;
    abort_d     = 1'b0;
    if (in_valid) begin
      case (mode)
        MODE_XOR: begin
          y_d         = x_c;
          beats_d     = COUNT_W'(1);
          out_valid_d = 1'b1;
          abort_d     = (fsm == ACC);
        end
        MODE_XNOR: begin
          y_d         = ~x_c;
          beats_d     = COUNT_W'(1);
          out_valid_d = 1'b1;
          abort_d     = (fsm == ACC);
        end
        MODE_ACC: begin
          if (in_last) begin
            y_d         = fold_c;
            beats_d     = cnt_inc_c;
            out_valid_d = 1'b1;
          end
        end
        default: begin
          y_d = y;
        end
      endcase
    end
    par_d = ^y_d;
  end

endmodule

// File: tb/tb_xor_bank_acc.sv
// Scoreboard bench for xor_bank_acc: default instance plus a COUNT_W=2
// instance sharing stimulus to exercise beat-counter saturation.
module tb_xor_bank_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_last;
  logic [1:0] mode;
  logic [3:0] a;
  logic [3:0] b;

  logic [3:0] y,  y2;
  logic       par, par2;
  logic       ov, ov2;
  logic [7:0] beats;
  logic [1:0] beats2;
  logic       ab, ab2;

  int tests  = 0;
  int errors = 0;

  typedef struct {
    logic       ov;
    logic [3:0] y;
    logic       par;
    int         beats8;
    int         beats2;
    logic       ab;
  } exp_t;

  exp_t exp_q[$];

  logic [3:0] m_acc;
  logic [3:0] m_y;
  int         m_cnt;
  int         m_beats;
  bit         m_open;

  always #5 clk = ~clk;

  xor_bank_acc #(.WIDTH(4), .COUNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
    .mode(mode), .a(a), .b(b), .y(y), .par(par), .out_valid(ov),
    .beats(beats), .abort(ab)
  );

  xor_bank_acc #(.WIDTH(4), .COUNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
    .mode(mode), .a(a), .b(b), .y(y2), .par(par2), .out_valid(ov2),
    .beats(beats2), .abort(ab2)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned want);
    tests++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model: unbounded beat count, clipped per counter width
  task automatic model(input logic r, input logic v, input logic [1:0] m,
                       input logic last, input logic [3:0] ia, input logic [3:0] ib);
    exp_t e;
    e.ov = 1'b0;
    e.ab = 1'b0;
    if (r) begin
      m_acc = '0; m_cnt = 0; m_open = 0; m_y = '0; m_beats = 0;
    end else if (v) begin
      if (m == 2'b00 || m == 2'b01) begin
        m_y = (m == 2'b01) ? ~(ia ^ ib) : (ia ^ ib);
        m_beats = 1;
        e.ov = 1'b1;
        if (m_open) begin
          e.ab = 1'b1;
          m_open = 0; m_acc = '0; m_cnt = 0;
        end
      end else if (m == 2'b10) begin
        if (last) begin
          m_y = m_acc ^ ia ^ ib;
          m_beats = m_cnt + 1;
          e.ov = 1'b1;
          m_open = 0; m_acc = '0; m_cnt = 0;
        end else begin
          m_acc = m_acc ^ ia ^ ib;
          m_cnt++;
          m_open = 1;
        end
      end
    end
    e.y      = m_y;
    e.par    = ^m_y;
    e.beats8 = (m_beats > 255) ? 255 : m_beats;
    e.beats2 = (m_beats > 3) ? 3 : m_beats;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic v, input logic [1:0] m,
                      input logic last, input logic [3:0] ia, input logic [3:0] ib);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = v; mode = m; in_last = last; a = ia; b = ib;
    model(r, v, m, last, ia, ib);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("out_valid", 32'(ov), 32'(e.ov));
    check("y", 32'(y), 32'(e.y));
    check("par", 32'(par), 32'(e.par));
    check("beats", 32'(beats), 32'(e.beats8));
    check("abort", 32'(ab), 32'(e.ab));
    check("out_valid_w2", 32'(ov2), 32'(e.ov));
    check("y_w2", 32'(y2), 32'(e.y));
    check("par_w2", 32'(par2), 32'(e.par));
    check("beats_w2", 32'(beats2), 32'(e.beats2));
    check("abort_w2", 32'(ab2), 32'(e.ab));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'b00, 1'b0, 4'h0, 4'h0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; mode = 2'b00; a = '0; b = '0;
    step(1'b1, 1'b0, 2'b00, 1'b0, 4'h0, 4'h0);
    step(1'b1, 1'b1, 2'b00, 1'b0, 4'hF, 4'h0);

    // Plain XOR then XNOR, with y holding across idle cycles
    step(1'b0, 1'b1, 2'b00, 1'b0, 4'b1010, 4'b0110);
    idle();
    idle();
    step(1'b0, 1'b1, 2'b01, 1'b1, 4'hF, 4'h3);
    idle();

    // Three-beat frame then an immediate single-beat frame
    step(1'b0, 1'b1, 2'b10, 1'b0, 4'h1, 4'h0);
    step(1'b0, 1'b1, 2'b10, 1'b0, 4'h2, 4'h0);
    step(1'b0, 1'b1, 2'b10, 1'b1, 4'h4, 4'h8);
    step(1'b0, 1'b1, 2'b10, 1'b1, 4'h5, 4'h0);
    idle();

    // Open frame aborted by a mode-00 beat, then a fresh frame
    step(1'b0, 1'b1, 2'b10, 1'b0, 4'h3, 4'h0);
    step(1'b0, 1'b1, 2'b10, 1'b0, 4'h5, 4'h0);
    step(1'b0, 1'b1, 2'b00, 1'b1, 4'h1, 4'h0);
    step(1'b0, 1'b1, 2'b10, 1'b1, 4'h6, 4'h0);

    // Five-beat frame with no-op beats and idle gaps mid-frame
    step(1'b0, 1'b1, 2'b10, 1'b0, 4'h1, 4'h0);
    step(1'b0, 1'b1, 2'b11, 1'b1, 4'hE, 4'h2);
    step(1'b0, 1'b1, 2'b10, 1'b0, 4'h1, 4'h0);
    idle();
    step(1'b0, 1'b1, 2'b10, 1'b0, 4'h1, 4'h0);
    step(1'b0, 1'b1, 2'b11, 1'b0, 4'h7, 4'h0);
    step(1'b0, 1'b1, 2'b10, 1'b0, 4'h1, 4'h0);
    step(1'b0, 1'b1, 2'b10, 1'b1, 4'h1, 4'h0);

    // Reset mid-frame drops the frame silently
    step(1'b0, 1'b1, 2'b10, 1'b0, 4'h3, 4'h0);
    step(1'b0, 1'b1, 2'b10, 1'b0, 4'hA, 4'h0);
    step(1'b1, 1'b1, 2'b00, 1'b0, 4'hF, 4'h0);
    step(1'b0, 1'b1, 2'b10, 1'b1, 4'h9, 4'h0);
    idle();

    // Random traffic across all modes
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 5) == 0), 4'($urandom), 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
